dshot_frame_tx: RTL
===================

Name: dshot_frame_tx

Overview:
- Per-motor DSHOT serializer that sits directly downstream of the DSHOT register block.
- Accepts an 11-bit throttle command plus a telemetry-request bit, computes the 4-bit CRC, and emits a 16-bit MSB-first DSHOT pulse train on one motor pin.
- Optionally re-sends the last command periodically, so ESCs keep receiving frames between register writes.
- Four instances feed the motor mux, one per o_motorN.

Parameters:
- CLK_HZ, 72000000, system clock frequency in Hz.
- DSHOT_KBPS, 150, DSHOT rate in kbit/s (150/300/600).
- GAP_BITS, 2, minimum idle-low time after each frame, in bit periods.
- REPEAT_HZ, 1000, auto-repeat frame rate.

Ports:
- i_sys_clk  in  1  system clock.
- i_rst  in  1  synchronous, active-high reset.
- i_valid  in  1  new command present.
- i_throttle  in  11  DSHOT value (0 disarm, 1-47 special, 48-2047 throttle).
- i_telem  in  1  telemetry-request bit.
- o_ready  out  1  command can be accepted this cycle.
- i_repeat_en  in  1  enables periodic retransmission of the last accepted command.
- o_dshot  out  1  motor line; idle low.
- o_busy  out  1  high from frame start through the end of the gap.
- o_frame_done  out  1  one-cycle pulse when the last bit's low phase completes.

Behaviour:
- Derived constants:
  - BIT = CLK_HZ/(DSHOT_KBPS*1000), which is 480 at the defaults.
  - T0H = BIT*3/8, which is 180 (2.5 us).
  - T1H = BIT*3/4, which is 360 (5.0 us).
  - REP = CLK_HZ/REPEAT_HZ, which is 72000.
- Frame construction:
  - v = {i_throttle, i_telem} (12 bits).
  - crc = (v ^ v>>4 ^ v>>8) & 4'hF.
  - frame = {v, crc}.
  - Frame and v are latched on accept (i_valid && o_ready).
- Reset values: o_dshot=0, o_busy=0, o_frame_done=0, o_ready=1. The state machine goes to IDLE, the latched frame is cleared to 0, and no repeat occurs until a command has been accepted.
- State machine:
  - IDLE:
    - o_ready=1.
    - On accept, latch the frame and go to HIGH with bit index 15.
    - Otherwise, if i_repeat_en, a frame has ever been latched, and the repeat counter has reached REP-1, go to HIGH using the stored frame.
  - HIGH:
    - o_dshot=1 for exactly T1H cycles if frame[idx]=1, else T0H cycles.
    - Then go to LOW.
  - LOW:
    - o_dshot=0 for BIT minus high-time cycles, so every bit period is exactly BIT cycles.
    - If idx>0, decrement idx and go to HIGH.
    - Otherwise pulse o_frame_done and go to GAP.
  - GAP:
    - o_dshot=0 for GAP_BITS*BIT cycles, then go to IDLE.
- Latency: o_dshot rises on the clock edge following the accept cycle.
- o_dshot is driven from a flop; no combinational glitches.
- o_ready is 0 in HIGH, LOW and GAP. Commands presented while busy are held off by the handshake, not dropped.
- Repeat counter:
  - Free-running modulo REP.
  - Restarts at 0 on every frame start (accepted or repeated).
  - If REP expires while busy, the repeat is deferred and issued on the first IDLE cycle.
- A new accept in the same cycle as a repeat expiry: the new command wins and the counter restarts.
- Clearing i_repeat_en mid-frame does not truncate the current frame; it only suppresses later repeats.
- Reset mid-frame: o_dshot goes low on the next edge, no o_frame_done is pulsed, and the stored frame is cleared.
- Counter widths are sized with $clog2 of the largest count (REP). No wrap-around of the timing counters is permitted within a phase.

Decomposition:
- dshot_pkg holds:
  - the state enum (IDLE, HIGH, LOW, GAP);
  - function dshot_crc(v[11:0]) returning [3:0];
  - function dshot_frame(throttle, telem) returning [15:0];
  - timing helper functions deriving BIT/T0H/T1H from CLK_HZ and DSHOT_KBPS.
- One sub-module, dshot_bit_timer:
  - a loadable down-counter with a terminal-count pulse;
  - shared by the HIGH/LOW/GAP phases.

Test Plan:
- Throttle 48, telem 0 -> frame 0x0606; high widths 180 or 360 cycles (2500/5000 ns); every bit period 480 cycles; one o_frame_done pulse.
- Throttle 1046, telem 1 -> v=0x82D, crc=7, frame 0x82D7 decoded MSB-first by the pulse-width monitor.
- Two back-to-back valids -> o_ready low during frame 1; frame 2 rises no earlier than 960 cycles after frame 1's last low phase.
- Accept throttle 48, then i_repeat_en=1 -> identical 0x0606 frames start every 72000 cycles; clearing i_repeat_en mid-frame finishes that frame and no further frames follow.
- Assert i_rst during bit 5 -> o_dshot low next cycle, o_ready=1, no o_frame_done; with repeat enabled, no frame until a new accept.
- Throttle 0, telem 0 -> frame 0x0000: 16 pulses of 180 cycles each, line stays low afterward.

Source files
------------

// File: rtl/dshot_pkg.sv
// Shared types and helpers for the DSHOT frame serializer: state encoding,
// frame/CRC construction and bit-timing derivation from the clock rate.
package dshot_pkg;

  localparam int THROTTLE_W = 11;
  localparam int FRAME_W    = 16;

  typedef enum logic [1:0] {IDLE, HIGH, LOW, GAP} dshot_state_t;

  function automatic logic [3:0] dshot_crc(input logic [11:0] v);
    return v[3:0] ^ v[7:4] ^ v[11:8];
  endfunction

  function automatic logic [15:0] dshot_frame(input logic [10:0] throttle, input logic telem);
    logic [11:0] v;
    v = {throttle, telem};
    return {v, dshot_crc(v)};
  endfunction

  function automatic int dshot_bit_cycles(input int clk_hz, input int kbps);
    return clk_hz / (kbps * 1000);
  endfunction

  function automatic int dshot_t0h(input int bit_len);
    return bit_len * 3 / 8;
  endfunction

  function automatic int dshot_t1h(input int bit_len);
    return bit_len * 3 / 4;
  endfunction

endpackage

// File: rtl/dshot_frame_tx_if.sv
// Command handshake and motor-line signals between the register block and
// one DSHOT serializer.
interface dshot_frame_tx_if;
  import dshot_pkg::*;

  logic                  i_valid;
  logic [THROTTLE_W-1:0] i_throttle;
  logic                  i_telem;
  logic                  o_ready;
  logic                  i_repeat_en;
  logic                  o_dshot;
  logic                  o_busy;
  logic                  o_frame_done;

  modport master (
    output i_valid, i_throttle, i_telem, i_repeat_en,
    input  o_ready, o_dshot, o_busy, o_frame_done
  );

  modport slave (
    input  i_valid, i_throttle, i_telem, i_repeat_en,
    output o_ready, o_dshot, o_busy, o_frame_done
  );

endinterface

// File: rtl/dshot_bit_timer.sv
// Loadable down-counter shared by the HIGH, LOW and GAP phases; tc is high
// while the count sits at zero, i.e. during the last cycle of a phase.
module dshot_bit_timer #(
  parameter int CW = 17
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          load,
  input  logic [CW-1:0] load_val,
  output logic          tc
);

  localparam logic [CW-1:0] ONE = CW'(1);

  logic [CW-1:0] count;

  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (count != '0) begin
      count <= count - ONE;
    end
  end

  assign tc = (count == '0);

endmodule

// File: rtl/dshot_frame_tx.sv
// Per-motor DSHOT serializer: latches throttle+telemetry, appends the CRC and
// shifts the 16-bit frame out MSB-first as pulse widths, with optional repeat.
module dshot_frame_tx
  import dshot_pkg::*;
#(
  parameter int CLK_HZ     = 72000000,
  parameter int DSHOT_KBPS = 150,
  parameter int GAP_BITS   = 2,
  parameter int REPEAT_HZ  = 1000
) (
  input  logic             i_sys_clk,
  input  logic             i_rst,
  dshot_frame_tx_if.slave  bus
);

  localparam int BIT_LEN = dshot_bit_cycles(CLK_HZ, DSHOT_KBPS);
  localparam int T0H     = dshot_t0h(BIT_LEN);
  localparam int T1H     = dshot_t1h(BIT_LEN);
  localparam int GAP_LEN = GAP_BITS * BIT_LEN;
  localparam int REP     = CLK_HZ / REPEAT_HZ;
  localparam int CW      = $clog2(REP > GAP_LEN ? REP : GAP_LEN);

  localparam logic [CW-1:0] T0H_M1   = CW'(T0H - 1);
  localparam logic [CW-1:0] T1H_M1   = CW'(T1H - 1);
  localparam logic [CW-1:0] LOW0_M1  = CW'(BIT_LEN - T0H - 1);
  localparam logic [CW-1:0] LOW1_M1  = CW'(BIT_LEN - T1H - 1);
  localparam logic [CW-1:0] GAP_M1   = CW'(GAP_LEN - 1);
  localparam logic [CW-1:0] REP_LAST = CW'(REP - 1);
  localparam logic [CW-1:0] ONE      = CW'(1);

  function automatic logic [CW-1:0] high_m1(input logic b);
    return b ? T1H_M1 : T0H_M1;
  endfunction

  function automatic logic [CW-1:0] low_m1(input logic b);
    return b ? LOW1_M1 : LOW0_M1;
  endfunction

  dshot_state_t  state, state_nxt;
  logic [3:0]    idx;
  logic [15:0]   frame_q, frame_new;
  logic          have_frame, rep_pend, rep_due;
  logic [CW-1:0] rep_cnt;
  logic          accept, start, timer_load, done_nxt, tc;
  logic [CW-1:0] timer_val;
  logic          dshot_q, busy_q, done_q;

  assign frame_new = dshot_frame(bus.i_throttle, bus.i_telem);
  assign rep_due   = bus.i_repeat_en && have_frame && (rep_cnt == REP_LAST || rep_pend);

  dshot_bit_timer #(.CW(CW)) u_timer (
    .clk      (i_sys_clk),
    .rst      (i_rst),
    .load     (timer_load),
    .load_val (timer_val),
    .tc       (tc)
  );

  always_comb begin
    state_nxt  = state;
    accept     = 1'b0;
    start      = 1'b0;
    timer_load = 1'b0;
    timer_val  = '0;
    done_nxt   = 1'b0;
    case (state)
      IDLE: begin
        // A fresh command takes priority over a due repeat.
        if (bus.i_valid) begin
          accept     = 1'b1;
          start      = 1'b1;
          state_nxt  = HIGH;
          timer_load = 1'b1;
          timer_val  = high_m1(frame_new[15]);
        end else if (rep_due) begin
          start      = 1'b1;
          state_nxt  = HIGH;
          timer_load = 1'b1;
          timer_val  = high_m1(frame_q[15]);
        end
      end
      HIGH: begin
        if (tc) begin
          state_nxt  = LOW;
          timer_load = 1'b1;
          timer_val  = low_m1(frame_q[idx]);
        end
      end
      LOW: begin
        if (tc) begin
          timer_load = 1'b1;
          if (idx != 4'd0) begin
            state_nxt = HIGH;
            timer_val = high_m1(frame_q[idx - 4'd1]);
          end else begin
            state_nxt = GAP;
            timer_val = GAP_M1;
            done_nxt  = 1'b1;
          end
        end
      end
      GAP: begin
        if (tc) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge i_sys_clk) begin
    if (i_rst) begin
      state      <= IDLE;
      idx        <= 4'd0;
      frame_q    <= '0;
      have_frame <= 1'b0;
      rep_cnt    <= '0;
      rep_pend   <= 1'b0;
      dshot_q    <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state <= state_nxt;
      if (start) idx <= 4'd15;
      else if (state == LOW && tc && idx != 4'd0) idx <= idx - 4'd1;
      if (accept) begin
        frame_q    <= frame_new;
        have_frame <= 1'b1;
      end
      if (start || rep_cnt == REP_LAST) rep_cnt <= '0;
      else rep_cnt <= rep_cnt + ONE;
      // Expiry during a frame is remembered so the repeat fires once idle.
      if (start) rep_pend <= 1'b0;
      else if (rep_cnt == REP_LAST && state != IDLE) rep_pend <= 1'b1;
      else if (!bus.i_repeat_en) rep_pend <= 1'b0;
      dshot_q <= (state_nxt == HIGH);
      busy_q  <= (state_nxt != IDLE);
      done_q  <= done_nxt;
    end
  end

  assign bus.o_ready      = (state == IDLE);
  assign bus.o_dshot      = dshot_q;
  assign bus.o_busy       = busy_q;
  assign bus.o_frame_done = done_q;

endmodule
